// File: rtl/fast_segment_test.sv
// FAST segment test: finds the longest circularly contiguous run in the bright/dark masks.
// Optional macro FAST_SEG_SKIP_EMPTY_EN sends all-zero mask pairs straight to DONE.
module fast_segment_test #(
  parameter int ARC_LEN = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bright_mask,
  input  logic [15:0] dark_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        is_corner,
  output logic        polarity,
  output logic [4:0]  arc_len,
  output logic [3:0]  arc_start,
  output logic [1:0]  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid-side data is held stable until that edge, ready may toggle freely.

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [4:0] run;
    logic [4:0] max;
    logic [3:0] start;
  } run_t;

  localparam logic [4:0] ARC = 5'(ARC_LEN);
  localparam logic [4:0] LAST_K = 5'd30;

  state_t      state;
  logic [15:0] b_mask;
  logic [15:0] d_mask;
  logic [4:0]  k;
  run_t        b_acc;
  run_t        d_acc;
  run_t        b_nxt;
  run_t        d_nxt;
  logic [10:0] sel;

  // One scan step for one polarity; the run saturates at a full circle.
  function automatic run_t step(input run_t cur, input logic bit_set, input logic [4:0] pos);
    run_t       nxt;
    logic [4:0] s5;
    nxt = cur;
    if (bit_set) nxt.run = (cur.run == 5'd16) ? 5'd16 : cur.run + 5'd1;
    else         nxt.run = 5'd0;
    s5 = pos - nxt.run + 5'd1;
    if (nxt.run > cur.max) begin
      nxt.max   = nxt.run;
      nxt.start = s5[3:0];
    end
    return nxt;
  endfunction

  // Result packing: {is_corner, polarity, arc_len, arc_start}
  function automatic logic [10:0] select_result(input run_t b, input run_t d);
    logic       bsel;
    logic [4:0] len;
    logic [3:0] st;
    bsel = (b.max >= ARC) || (!(d.max >= ARC) && (b.max >= d.max));
    len  = bsel ? b.max : d.max;
    st   = bsel ? b.start : d.start;
    return {len >= ARC, bsel, len, st};
  endfunction

  always_comb begin
    b_nxt = step(b_acc, b_mask[k[3:0]], k);
    d_nxt = step(d_acc, d_mask[k[3:0]], k);
    sel   = select_result(b_nxt, d_nxt);
  end

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      b_mask    <= '0;
      d_mask    <= '0;
      k         <= '0;
      b_acc     <= '0;
      d_acc     <= '0;
      out_valid <= 1'b0;
      is_corner <= 1'b0;
      polarity  <= 1'b0;
      arc_len   <= '0;
      arc_start <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_mask <= bright_mask;
            d_mask <= dark_mask;
            b_acc  <= '0;
            d_acc  <= '0;
            k      <= '0;
`ifdef FAST_SEG_SKIP_EMPTY_EN
            if (bright_mask == 16'd0 && dark_mask == 16'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              is_corner <= 1'b0;
              polarity  <= 1'b1;
              arc_len   <= '0;
              arc_start <= '0;
            end else begin
              state <= SCAN;
            end
`else
            state <= SCAN;
`endif
          end
        end
        SCAN: begin
          b_acc <= b_nxt;
          d_acc <= d_nxt;
          k     <= k + 5'd1;
          // 31 positions cover every run that wraps past index 15.
          if (k == LAST_K) begin
            state     <= DONE;
            out_valid <= 1'b1;
            is_corner <= sel[10];
            polarity  <= sel[9];
            arc_len   <= sel[8:4];
            arc_start <= sel[3:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_segment_test.sv
// Bench for fast_segment_test: directed corner cases plus random masks against a run-search model.
module tb_fast_segment_test;
  localparam int ARC_LEN = 9;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bright_mask;
  logic [15:0] dark_mask;
  logic        out_valid;
  logic        out_ready;
  logic        is_corner;
  logic        polarity;
  logic [4:0]  arc_len;
  logic [3:0]  arc_start;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  fast_segment_test #(.ARC_LEN(ARC_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bright_mask(bright_mask), .dark_mask(dark_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_corner(is_corner), .polarity(polarity),
    .arc_len(arc_len), .arc_start(arc_start), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Longest circular run: scan every run start, ties go to the lowest start.
  function automatic void best_run(input logic [15:0] m, output int len, output int st);
    len = 0;
    st  = 0;
    if (m == 16'hFFFF) begin
      len = 16;
    end else begin
      for (int s = 0; s < 16; s++) begin
        if (m[s] && !m[(s + 15) % 16]) begin
          int l;
          l = 0;
          while (l < 16 && m[(s + l) % 16]) l++;
          if (l > len) begin
            len = l;
            st  = s;
          end
        end
      end
    end
  endfunction

  function automatic logic [10:0] model(input logic [15:0] b, input logic [15:0] d);
    int bl, bs, dl, ds, len, st;
    logic pol;
    best_run(b, bl, bs);
    best_run(d, dl, ds);
    if (bl >= ARC_LEN)      pol = 1'b1;
    else if (dl >= ARC_LEN) pol = 1'b0;
    else                    pol = (bl >= dl);
    len = pol ? bl : dl;
    st  = pol ? bs : ds;
    return {len >= ARC_LEN, pol, 5'(len), 4'(st)};
  endfunction

  function automatic logic [15:0] make_arc(input int len, input int st);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < len; i++) m[(st + i) % 16] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs(input string tag, input logic [10:0] exp);
    check({tag, "_is_corner"}, 32'(is_corner), 32'(exp[10]));
    check({tag, "_polarity"},  32'(polarity),  32'(exp[9]));
    check({tag, "_arc_len"},   32'(arc_len),   32'(exp[8:4]));
    check({tag, "_arc_start"}, 32'(arc_start), 32'(exp[3:0]));
  endtask

  task automatic send(input logic [15:0] b, input logic [15:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    bright_mask = b;
    dark_mask   = d;
    in_valid    = 1'b1;
    exp_q.push_back(model(b, d));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input logic [15:0] b, input logic [15:0] d);
    int n;
    int exp_lat;
    n = 0;
    exp_lat = 31;
`ifdef FAST_SEG_SKIP_EMPTY_EN
    if (b == 16'd0 && d == 16'd0) exp_lat = 0;
`endif
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic take_result(input int hold);
    logic [10:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
    check_outputs("result", exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check_outputs("hold", exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("ready_after_accept", 32'(in_ready), 32'd1);
  endtask

  task automatic txn(input logic [15:0] b, input logic [15:0] d, input int hold);
    send(b, d);
    wait_result(b, d);
    take_result(hold);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_is_corner"}, 32'(is_corner), 32'd0);
    check({tag, "_polarity"},  32'(polarity),  32'd0);
    check({tag, "_arc_len"},   32'(arc_len),   32'd0);
    check({tag, "_arc_start"}, 32'(arc_start), 32'd0);
  endtask

  initial begin
    logic [15:0] b, d;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    bright_mask = '0;
    dark_mask   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed cases: plain arc, wrap, sub-threshold, saturation, empty.
    txn(16'h01FF, 16'h0000, 0);
    txn(16'hC07F, 16'h0000, 1);
    txn(16'h0100, 16'h00FF, 0);
    txn(16'hFFFF, 16'h0000, 0);
    txn(16'h0000, 16'hFFFF, 2);
    txn(16'h0000, 16'h0000, 0);
    txn(16'h0FFF, 16'hFFF0, 0);
    txn(16'h0F0F, 16'hF0F0, 0);

    // Backpressure with a competing request that must not be taken.
    send(16'h3FE0, 16'h0003);
    wait_result(16'h3FE0, 16'h0003);
    bright_mask = 16'hFFFF;
    dark_mask   = 16'h0000;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check_outputs("bp", exp_q[0]);
    end
    in_valid = 1'b0;
    take_result(0);

    // Reset in the middle of a scan discards the pair.
    send(16'h01FF, 16'h0000);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midscan_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_valid", 32'(out_valid), 32'd0);
    txn(16'h0000, 16'h0000, 0);
    txn(16'hC07F, 16'h0000, 0);

    // Random masks: pure noise, planted bright arcs, planted dark arcs.
    for (int t = 0; t < 40; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      b = 16'($urandom);
      d = 16'($urandom) & ~b;
      if (mode == 1) begin
        b = make_arc($urandom_range(1, 16), $urandom_range(0, 15));
        d = 16'($urandom) & ~b;
      end else if (mode == 2) begin
        d = make_arc($urandom_range(1, 16), $urandom_range(0, 15));
        b = 16'($urandom) & ~d;
      end
      txn(b, d, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fast_segment_test.md
# fast_segment_test

Sequential FAST segment-test stage: consumes the 16-bit bright/dark masks produced by the FAST threshold-compare stage and finds the longest circularly contiguous run of set bits in each mask. It reports whether the pixel is a corner (run ≥ ARC_LEN), its polarity, and the winning arc's length and start index. It sits directly downstream of the threshold comparator in the feature-extractor pipeline and feeds corner scoring/NMS over a valid/ready handshake.

## Interface
- ARC_LEN, 9, minimum contiguous arc length for a corner; legal range 1..16.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  mask pair valid.
- in_ready  output  1  block can accept a mask pair.
- bright_mask  input  16  bit i set = circle pixel i brighter than center+threshold.
- dark_mask  input  16  bit i set = circle pixel i darker than center−threshold.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- is_corner  output  1  winning run length ≥ ARC_LEN.
- polarity  output  1  1 = bright arc, 0 = dark arc.
- arc_len  output  5  winning run length, 0..16.
- arc_start  output  4  circle index of first bit of winning run.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch both masks, clear run/max counters, k=0, go to SCAN.
- SCAN: each cycle process bit index k (0..30) of each mask at position (k mod 16), bright and dark in parallel. Per polarity: if bit set, run = min(run+1, 16), else run = 0. If run > max (strict), max = run, start = (k − run + 1) mod 16. After k=30, go to DONE. Scanning 31 positions captures all wrap-around runs.
- DONE: register results, out_valid=1. Selection: if bright_max ≥ ARC_LEN → polarity=1; else if dark_max ≥ ARC_LEN → polarity=0; else the polarity with the larger max, ties → bright. arc_len/arc_start taken from the selected polarity. is_corner = selected max ≥ ARC_LEN. Masks with both bright and dark qualifying resolve to bright.
- DONE → IDLE on out_valid && out_ready; out_valid drops the following cycle.
- All-zero masks: arc_len=0, arc_start=0, polarity=1, is_corner=0.
- in_valid outside IDLE is ignored (in_ready=0); upstream must hold.
- Reset mid-operation: FSM returns to IDLE, latched masks discarded, all outputs to reset values.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, is_corner=0, polarity=0, arc_len=0, arc_start=0.
- Accept at cycle T; SCAN occupies T+1..T+31; out_valid=1 from T+32.
- Outputs stable while out_valid && !out_ready.
- Accept at cycle A of the result → in_ready=1 at A+1; minimum initiation interval 33 cycles.

## Configuration
- FAST_SEG_SKIP_EMPTY_EN: when defined, an accepted pair with bright_mask==0 and dark_mask==0 bypasses SCAN: IDLE → DONE directly, out_valid at T+1 with the all-zero-mask result. When undefined, every pair takes the full 31-cycle SCAN; results are identical, only latency differs.

## Test plan
- ARC_LEN=9, bright=16'h01FF, dark=0 → out_valid at T+32, is_corner=1, polarity=1, arc_len=9, arc_start=0.
- Wrap: bright=16'hC07F, dark=0 → is_corner=1, polarity=1, arc_len=9, arc_start=14.
- Sub-threshold: bright=16'h0100, dark=16'h00FF → is_corner=0, polarity=0, arc_len=8, arc_start=0.
- Saturation: bright=16'hFFFF → arc_len=16, arc_start=0, is_corner=1; dark=16'hFFFF alone → polarity=0, arc_len=16.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs unchanged, in_ready=0, a second in_valid not accepted; raise out_ready → in_ready=1 next cycle.
- Reset at T+10 mid-SCAN → all outputs at reset values, in_ready=1 after release; with FAST_SEG_SKIP_EMPTY_EN, zero masks → out_valid at T+1, arc_len=0.
